// File: rtl/fdct4_serial.sv
// Forward 4-point HEVC core transform, one 1-D pass: four samples in serially,
// even/odd butterfly in a single cycle, four rounded/shifted/saturated coefficients out.
module fdct4_serial #(
    parameter int IN_W  = 25,
    parameter int OUT_W = 25,
    parameter int SHIFT = 1,
    parameter int ADD   = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [IN_W-1:0]  d_in,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [OUT_W-1:0] d_out,
    output logic [1:0]              out_idx
);

    localparam int IW = IN_W + 10;
    localparam logic signed [IW-1:0] C83   = IW'(83);
    localparam logic signed [IW-1:0] C36   = IW'(36);
    localparam logic signed [IW-1:0] ADD_S = IW'(ADD);
    localparam logic signed [IW-1:0] MAXV  = {{(IW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [IW-1:0] MINV  = {{(IW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    typedef enum logic [1:0] {LOAD, CALC, SEND} state_t;

    state_t                  r_state;
    state_t                  w_next;
    logic [1:0]              r_cnt;
    logic [1:0]              r_k;
    logic signed [IN_W-1:0]  r_x    [4];
    logic signed [OUT_W-1:0] r_coef [4];

    logic                    w_acc;
    logic                    w_hs;
    logic signed [IW-1:0]    w_xe  [4];
    logic signed [IW-1:0]    w_y   [4];
    logic signed [IW-1:0]    w_sh  [4];
    logic signed [OUT_W-1:0] w_sat [4];
    logic signed [IW-1:0]    w_e0, w_e1, w_o0, w_o1;

    assign w_acc = in_valid && in_ready;
    assign w_hs  = out_valid && out_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= LOAD;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            LOAD:    if (w_acc && r_cnt == 2'd3) w_next = CALC;
            CALC:    w_next = SEND;
            SEND:    if (w_hs && r_k == 2'd3) w_next = LOAD;
            default: w_next = LOAD;
        endcase
    end

    // Butterfly runs at IN_W+10 bits, wide enough that no intermediate can overflow.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            w_xe[i] = {{(IW-IN_W){r_x[i][IN_W-1]}}, r_x[i]};
        end
        w_e0   = w_xe[0] + w_xe[3];
        w_e1   = w_xe[1] + w_xe[2];
        w_o0   = w_xe[0] - w_xe[3];
        w_o1   = w_xe[1] - w_xe[2];
        w_y[0] = (w_e0 + w_e1) <<< 6;
        w_y[2] = (w_e0 - w_e1) <<< 6;
        w_y[1] = C83 * w_o0 + C36 * w_o1;
        w_y[3] = C36 * w_o0 - C83 * w_o1;
        for (int i = 0; i < 4; i++) begin
            w_sh[i] = (w_y[i] + ADD_S) >>> SHIFT;
            if (w_sh[i] > MAXV)      w_sat[i] = MAXV[OUT_W-1:0];
            else if (w_sh[i] < MINV) w_sat[i] = MINV[OUT_W-1:0];
            else                     w_sat[i] = w_sh[i][OUT_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt     <= '0;
            r_k       <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            d_out     <= '0;
            out_idx   <= '0;
            // NOTE: sample/coefficient storage is only 8 words, so clearing it on reset is cheap and keeps d_out deterministic.
            for (int i = 0; i < 4; i++) begin
                r_x[i]    <= '0;
                r_coef[i] <= '0;
            end
        end else begin
            in_ready  <= (w_next == LOAD);
            out_valid <= (w_next == SEND);
            case (r_state)
                LOAD: begin
                    if (w_acc) begin
                        r_x[r_cnt] <= d_in;
                        r_cnt      <= r_cnt + 2'd1;
                    end
                end
                CALC: begin
                    for (int i = 0; i < 4; i++) r_coef[i] <= w_sat[i];
                    r_k     <= 2'd0;
                    d_out   <= w_sat[0];
                    out_idx <= 2'd0;
                end
                SEND: begin
                    if (w_hs) begin
                        if (r_k == 2'd3) begin
                            r_k     <= 2'd0;
                            d_out   <= '0;
                            out_idx <= 2'd0;
                        end else begin
                            r_k     <= r_k + 2'd1;
                            d_out   <= r_coef[r_k + 2'd1];
                            out_idx <= r_k + 2'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/fdct4_serial.md
Name: fdct4_serial

Overview:
- Forward 4-point HEVC core transform, one 1-D pass (row or column); the encoder-side counterpart of the 4-point IDCT stage blocks.
- Accepts 4 residual samples serially over a valid/ready stream and computes all 4 coefficients in one cycle using an even/odd butterfly.
- Emits the coefficients serially with rounding, arithmetic shift and saturation.
- Sits between residual generation and the second-pass transpose buffer.

Parameters:
- IN_W, 25, signed input sample width.
- OUT_W, 25, signed output coefficient width.
- SHIFT, 1, arithmetic right shift applied to each coefficient; must be >= 1.
- ADD, 1, rounding offset added before the shift; the integrator sets it to 1<<(SHIFT-1).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous reset, active-low: 0 resets, 1 runs.
- in_valid  input  1  d_in carries a valid sample.
- in_ready  output  1  block accepts a sample this cycle.
- d_in  input  IN_W  signed sample; sample order within a block is x0,x1,x2,x3.
- out_valid  output  1  d_out and out_idx are valid.
- out_ready  input  1  downstream accepts the output this cycle.
- d_out  output  OUT_W  signed coefficient.
- out_idx  output  2  coefficient index of d_out (0..3).

Behaviour:
- Async reset (reset==0):
  - state=LOAD, sample counter=0, output counter=0.
  - in_ready=1 (registered), out_valid=0, d_out=0, out_idx=0.
  - Sample and coefficient registers cleared.
  - Takes effect immediately, including mid-block; any partial block is discarded.
- States: LOAD, CALC, SEND.
- LOAD:
  - in_ready=1; a sample is accepted when in_valid&&in_ready and is stored as x[cnt]; cnt increments.
  - Acceptance with cnt==3 -> CALC; cnt wraps to 0.
  - Gaps in in_valid are allowed; cnt holds.
- CALC (exactly 1 cycle, in_ready=0):
  - Butterfly: e0=x0+x3, e1=x1+x2, o0=x0-x3, o1=x1-x2.
  - Coefficients: Y0=64*(e0+e1); Y2=64*(e0-e1); Y1=83*o0+36*o1; Y3=36*o0-83*o1.
  - Internal width IN_W+10 signed; no internal overflow is possible.
  - Each Yk -> (Yk+ADD)>>>SHIFT, then saturated to the signed OUT_W range [-2^(OUT_W-1), 2^(OUT_W-1)-1].
  - Results are stored in 4 coefficient registers; next state is SEND with the output counter at 0.
- SEND:
  - out_valid=1; d_out=coef[k], out_idx=k, emitted in order k=0,1,2,3.
  - k advances only on out_valid&&out_ready.
  - d_out and out_idx stay stable while out_ready=0; there is no timeout.
  - Handshake with k==3 -> LOAD; out_valid drops the next cycle and in_ready rises the same cycle.
  - in_ready=0 throughout SEND; no overlap of load and send.
- Latency: last sample accepted at edge t -> CALC during cycle t+1 -> out_valid=1 with Y0 from edge t+2.
- Minimum block period: 4 load + 1 calc + 4 send = 9 cycles with in_valid and out_ready held high.
- in_valid asserted during CALC or SEND is ignored; the source must hold its sample until in_ready.
- All outputs are registered; there is no combinational path from in_valid or out_ready to any output.

Test Plan:
- Reset low mid-LOAD after 2 samples, then release and send x=[1,2,3,4] -> in_ready=1 and out_valid=0 during reset; the 2 stale samples are discarded; outputs (idx0..3)=320,-142,0,-12.
- Stream [10,10,10,10] with out_ready=1 -> out_valid first rises 2 cycles after the 4th accept; d_out=1280,0,0,0 with idx 0..3; in_ready returns 1 the cycle after idx3.
- x=[1,2,3,4] with out_ready low for 3 cycles during idx1 -> d_out holds -142 and idx holds 1 throughout; the sequence resumes with 0,-12; no coefficient is lost or duplicated.
- All inputs 16777215, then all -16777216 -> Y0 saturates to 16777215 and to -16777216 respectively; Y1..Y3=0 in both blocks.
- Two back-to-back blocks [1,2,3,4],[10,10,10,10] with in_valid held high -> in_ready=0 during CALC and SEND; the second block's samples enter only after idx3 of the first; outputs 320,-142,0,-12,1280,0,0,0.
- Reset low while in SEND at idx2 -> out_valid=0 and d_out=0 immediately (asynchronously); after release the block is in LOAD with in_ready=1.
